// File: rtl/fpu_dispatch_if.sv
// Issue/result handshake bundle for the FPU dispatcher.
// Master drives requests and result_ready; slave is the dispatcher.
interface fpu_dispatch_if #(
  parameter int W    = 32,
  parameter int TAGW = 5,
  parameter int OPW  = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  operator;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [TAGW-1:0] tag;
  logic            result_valid;
  logic            result_ready;
  logic [W-1:0]    c;
  logic [TAGW-1:0] result_tag;
  logic            result_err;

  modport master (
    output in_valid, operator, a, b, tag,
    output result_ready,
    input  in_ready,
    input  result_valid, c, result_tag, result_err
  );

  modport slave (
    input  in_valid, operator, a, b, tag,
    input  result_ready,
    output in_ready,
    output result_valid, c, result_tag, result_err
  );
endinterface

// File: rtl/fpu_dispatch.sv
// FPU front end: issues ops to NUNIT AXI-stream units, returns results in order.
// Define FPU_DISPATCH_SIGNOP_EN to add NEG/ABS on the internal path.
module fpu_dispatch #(
  parameter int W     = 32,
  parameter int NUNIT = 5,
  parameter int DEPTH = 8,
  parameter int TAGW  = 5,
  parameter int OPW   = 3
) (
  input  logic                       CLK,
  input  logic                       INITIALIZE,
  fpu_dispatch_if.slave              bus,
  output logic                       unit_aresetn,
  output logic [NUNIT-1:0]           unit_in_valid,
  input  logic [NUNIT-1:0]           unit_in_ready,
  output logic [W-1:0]               unit_a,
  output logic [W-1:0]               unit_b,
  input  logic [NUNIT-1:0]           unit_res_valid,
  output logic [NUNIT-1:0]           unit_res_ready,
  input  logic [NUNIT*W-1:0]         unit_res_data,
  output logic [$clog2(DEPTH+1)-1:0] inflight
);

  localparam int IDW = $clog2(NUNIT + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  localparam logic [IDW-1:0] INT  = IDW'(NUNIT);
  localparam logic [W-1:0]   QNAN = W'(32'h7FC0_0000);

  typedef enum logic [1:0] {
    RS_HOLD,
    RS_WAIT1,
    RS_WAIT2,
    RS_RUN
  } rs_t;

  rs_t  rs_q;
  rs_t  rs_d;
  logic aresetn_q;
  logic rst_busy;

  logic [PW-1:0]   wp_q;
  logic [PW-1:0]   rp_q;
  logic [CW-1:0]   cnt_q;
  logic [IDW-1:0]  f_id  [DEPTH];
  logic [TAGW-1:0] f_tag [DEPTH];
  logic            f_ill [DEPTH];

  logic            int_valid_q;
  logic [W-1:0]    int_data_q;
  logic [W-1:0]    int_res;
  logic            int_ill;

  logic            res_valid_q;
  logic [W-1:0]    c_q;
  logic [TAGW-1:0] rtag_q;
  logic            rerr_q;

  logic [NUNIT-1:0] op_hot;
  logic             is_ext;
  logic             ext_rdy;
  logic             full;
  logic             empty;
  logic             in_ready;
  logic             push;
  logic [IDW-1:0]   push_id;
  logic             push_ill;

  logic [IDW-1:0]   head;
  logic [W-1:0]     head_data;
  logic             src_ok;
  logic             out_free;
  logic             load;
  logic             int_pop;

  // Units get the INITIALIZE cycle plus two more of low reset, registered.
  always_ff @(posedge CLK) begin
    if (INITIALIZE) begin
      rs_q      <= RS_HOLD;
      aresetn_q <= 1'b0;
    end else begin
      rs_q      <= rs_d;
      aresetn_q <= (rs_d == RS_RUN);
    end
  end

  always_comb begin
    rs_d = rs_q;
    case (rs_q)
      RS_HOLD:  rs_d = RS_WAIT1;
      RS_WAIT1: rs_d = RS_WAIT2;
      RS_WAIT2: rs_d = RS_RUN;
      default:  rs_d = RS_RUN;
    endcase
  end

  assign rst_busy     = INITIALIZE || (rs_q != RS_RUN);
  assign unit_aresetn = aresetn_q;

  always_comb begin
    op_hot = '0;
    for (int u = 0; u < NUNIT; u++) begin
      op_hot[u] = (bus.operator == OPW'(u));
    end
  end

  assign is_ext  = (bus.operator < OPW'(NUNIT));
  assign ext_rdy = |(op_hot & unit_in_ready);
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);

`ifdef FPU_DISPATCH_SIGNOP_EN
  always_comb begin
    int_res = QNAN;
    int_ill = 1'b1;
    unique case (1'b1)
      (bus.operator == OPW'(NUNIT)): begin
        int_res = {~bus.a[W-1], bus.a[W-2:0]};
        int_ill = 1'b0;
      end
      (bus.operator == OPW'(NUNIT + 1)): begin
        int_res = {1'b0, bus.a[W-2:0]};
        int_ill = 1'b0;
      end
      default: ;
    endcase
  end
`else
  assign int_res = QNAN;
  assign int_ill = 1'b1;
`endif

  assign in_ready = !full && !rst_busy &&
                    (is_ext ? ext_rdy : (!int_valid_q || int_pop));

  assign unit_in_valid =
    (bus.in_valid && !full && !rst_busy) ? op_hot : '0;

  assign unit_a = bus.a;
  assign unit_b = bus.b;

  assign push     = bus.in_valid && in_ready;
  assign push_id  = is_ext ? IDW'(bus.operator) : INT;
  assign push_ill = !is_ext && int_ill;

  assign head = f_id[rp_q];

  always_comb begin
    src_ok    = 1'b0;
    head_data = int_data_q;
    for (int u = 0; u < NUNIT; u++) begin
      if (head == IDW'(u)) begin
        src_ok    = unit_res_valid[u];
        head_data = unit_res_data[u*W +: W];
      end
    end
    if (head == INT) begin
      src_ok = int_valid_q;
    end
  end

  assign out_free = !res_valid_q || bus.result_ready;
  assign load     = !empty && !rst_busy && src_ok && out_free;
  assign int_pop  = load && (head == INT);

  always_comb begin
    unit_res_ready = '0;
    for (int u = 0; u < NUNIT; u++) begin
      unit_res_ready[u] = !empty && !rst_busy && out_free &&
                          (head == IDW'(u));
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      f_id[wp_q]  <= push_id;
      f_tag[wp_q] <= bus.tag;
      f_ill[wp_q] <= push_ill;
    end
  end

  always_ff @(posedge CLK) begin
    if (INITIALIZE) begin
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      int_valid_q <= 1'b0;
      int_data_q  <= '0;
      res_valid_q <= 1'b0;
      c_q         <= '0;
      rtag_q      <= '0;
      rerr_q      <= 1'b0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (load) rp_q <= rp_q + 1'b1;
      case ({push, load})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
      if (push && !is_ext) begin
        int_valid_q <= 1'b1;
        int_data_q  <= int_res;
      end else if (int_pop) begin
        int_valid_q <= 1'b0;
      end
      if (load) begin
        res_valid_q <= 1'b1;
        c_q         <= head_data;
        rtag_q      <= f_tag[rp_q];
        rerr_q      <= f_ill[rp_q];
      end else if (bus.result_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.result_valid = res_valid_q;
  assign bus.c            = c_q;
  assign bus.result_tag   = rtag_q;
  assign bus.result_err   = rerr_q;
  assign inflight         = cnt_q;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed bench for fpu_dispatch with behavioural pipelined unit models.
// Unit u returns a + b + u after a per-unit latency.
module tb_fpu_dispatch;

  logic clk = 1'b0;
  logic init = 1'b1;
  always #5 clk = ~clk;

  fpu_dispatch_if #(.W(32), .TAGW(5), .OPW(3)) bus();

  logic         unit_aresetn;
  logic [4:0]   unit_in_valid;
  logic [4:0]   unit_in_ready = 5'b11111;
  logic [31:0]  unit_a;
  logic [31:0]  unit_b;
  wire  [4:0]   unit_res_valid;
  logic [4:0]   unit_res_ready;
  wire  [159:0] unit_res_data;
  logic [3:0]   inflight;

  fpu_dispatch #(
    .W(32), .NUNIT(5), .DEPTH(8), .TAGW(5), .OPW(3)
  ) dut (
    .CLK            (clk),
    .INITIALIZE     (init),
    .bus            (bus),
    .unit_aresetn   (unit_aresetn),
    .unit_in_valid  (unit_in_valid),
    .unit_in_ready  (unit_in_ready),
    .unit_a         (unit_a),
    .unit_b         (unit_b),
    .unit_res_valid (unit_res_valid),
    .unit_res_ready (unit_res_ready),
    .unit_res_data  (unit_res_data),
    .inflight       (inflight)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int u);
    case (u)
      0, 1:    return 11;
      2:       return 5;
      3:       return 28;
      default: return 3;
    endcase
  endfunction

  for (genvar u = 0; u < 5; u++) begin : g_unit
    logic [31:0] qd [$];
    int          qt [$];
    logic        v = 1'b0;
    logic [31:0] d = '0;
    assign unit_res_valid[u] = v;
    assign unit_res_data[u*32 +: 32] = d;
    always @(posedge clk) begin
      if (!unit_aresetn) begin
        qd.delete();
        qt.delete();
      end else begin
        if (v && unit_res_ready[u]) begin
          qd.delete(0);
          qt.delete(0);
        end
        if (unit_in_valid[u] && unit_in_ready[u]) begin
          qd.push_back(unit_a + unit_b + 32'(u));
          qt.push_back(cyc + lat(u));
        end
      end
      v <= 1'b0;
      d <= '0;
      if (qt.size() > 0) begin
        if (qt[0] <= cyc + 1) begin
          v <= 1'b1;
          d <= qd[0];
        end
      end
    end
  end

  typedef struct packed {
    logic [31:0] c;
    logic [4:0]  tag;
    logic        err;
  } res_t;

  res_t rq [$];

  always @(negedge clk) begin
    #2;
    if (bus.result_valid && bus.result_ready)
      rq.push_back({bus.c, bus.result_tag, bus.result_err});
  end

  task automatic send(input logic [2:0] op, input logic [31:0] x,
                      input logic [31:0] y, input logic [4:0] t);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.operator = op;
    bus.a = x;
    bus.b = y;
    bus.tag = t;
    #1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept tag=%0d: in_ready=%b want 1", t, bus.in_ready);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input string nm);
    int k;
    k = 0;
    while (rq.size() < n && k < 200) begin
      @(negedge clk);
      #3;
      k++;
    end
    total++;
    if (rq.size() < n) begin
      bad++;
      $display("FAIL %s count: got %0d want %0d", nm, rq.size(), n);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1;
    bus.operator = 3'd0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready);
    end
    total++;
    if ({bus.result_valid, bus.result_err} !== 2'b00) begin
      bad++; $display("FAIL rst_valid_err: got %b%b want 00",
                      bus.result_valid, bus.result_err);
    end
    total++;
    if ({bus.c, bus.result_tag} !== 37'd0) begin
      bad++; $display("FAIL rst_c_tag: got %h/%0d want 0/0",
                      bus.c, bus.result_tag);
    end
    total++;
    if (inflight !== 4'd0) begin
      bad++; $display("FAIL rst_inflight: got %0d want 0", inflight);
    end
    total++;
    if ({unit_aresetn, unit_in_valid, unit_res_ready} !== 11'd0) begin
      bad++; $display("FAIL rst_unit: got %b %b %b want 0 0 0",
                      unit_aresetn, unit_in_valid, unit_res_ready);
    end
    @(negedge clk);
    init = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      #1;
      total++;
      if ({bus.in_ready, unit_aresetn} !== {2{k == 3}}) begin
        bad++; $display("FAIL rst_release k=%0d: rdy=%b aresetn=%b want %b",
                        k, bus.in_ready, unit_aresetn, k == 3);
      end
    end
  endtask

  task automatic test_order();
    bit leak;
    bit div_taken;
    int n;
    @(negedge clk);
    bus.result_ready = 1'b1;
    rq.delete();
    send(3'd3, 32'd10, 32'd5, 5'd1);
    send(3'd0, 32'd1, 32'd2, 5'd2);
    idle();
    leak = 0;
    div_taken = 0;
    n = 0;
    while (rq.size() < 2 && n < 100) begin
      @(negedge clk);
      #1;
      if (!div_taken && unit_res_ready[0]) leak = 1;
      if (unit_res_valid[3] && unit_res_ready[3]) div_taken = 1;
      n++;
    end
    total++;
    if (leak !== 1'b0) begin
      bad++; $display("FAIL order_backpressure: add ready early=%b want 0", leak);
    end
    wait_results(2, "order");
    if (rq.size() >= 2) begin
      total++;
      if ({rq[0].tag, rq[0].c, rq[0].err} !== {5'd1, 32'd18, 1'b0}) begin
        bad++; $display("FAIL order_first: tag=%0d c=%0d want 1/18",
                        rq[0].tag, rq[0].c);
      end
      total++;
      if ({rq[1].tag, rq[1].c, rq[1].err} !== {5'd2, 32'd3, 1'b0}) begin
        bad++; $display("FAIL order_second: tag=%0d c=%0d want 2/3",
                        rq[1].tag, rq[1].c);
      end
    end
  endtask

  task automatic test_fill_drain();
    @(negedge clk);
    bus.result_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(3'd0, 32'(i), 32'd100, 5'(i));
    @(negedge clk);
    bus.a = 32'd8;
    bus.tag = 5'd8;
    #1;
    total++;
    if (inflight !== 4'd8) begin
      bad++; $display("FAIL fill_inflight: got %0d want 8", inflight);
    end
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL fill_ready9: got %b want 0", bus.in_ready);
    end
    bus.in_valid = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    total++;
    if ({bus.result_valid, bus.result_tag, bus.c, inflight} !==
        {1'b1, 5'd0, 32'd100, 4'd7}) begin
      bad++; $display("FAIL fill_hold: v=%b tag=%0d c=%0d infl=%0d want 1/0/100/7",
                      bus.result_valid, bus.result_tag, bus.c, inflight);
    end
    @(negedge clk);
    bus.result_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({bus.result_valid, bus.result_tag, bus.c} !==
          {1'b1, 5'(i), 32'(100 + i)}) begin
        bad++; $display("FAIL drain_%0d: v=%b tag=%0d c=%0d want 1/%0d/%0d",
                        i, bus.result_valid, bus.result_tag, bus.c, i, 100 + i);
      end
      @(negedge clk);
      #1;
    end
    total++;
    if ({bus.result_valid, inflight} !== 5'd0) begin
      bad++; $display("FAIL drain_end: v=%b infl=%0d want 0/0",
                      bus.result_valid, inflight);
    end
  endtask

  task automatic test_signop();
    logic [32:0] e0;
    logic [32:0] e1;
`ifdef FPU_DISPATCH_SIGNOP_EN
    e0 = {32'hBF80_0000, 1'b0};
    e1 = {32'h3F80_0000, 1'b0};
`else
    e0 = {32'h7FC0_0000, 1'b1};
    e1 = {32'h7FC0_0000, 1'b1};
`endif
    rq.delete();
    send(3'd5, 32'h3F80_0000, 32'd0, 5'd9);
    send(3'd6, 32'hBF80_0000, 32'd0, 5'd10);
    send(3'd7, 32'h3F80_0000, 32'd0, 5'd11);
    idle();
    wait_results(3, "signop");
    if (rq.size() >= 3) begin
      total++;
      if ({rq[0].c, rq[0].err} !== e0 || rq[0].tag !== 5'd9) begin
        bad++; $display("FAIL sign_neg: c=%h err=%b tag=%0d want %h/%b/9",
                        rq[0].c, rq[0].err, rq[0].tag, e0[32:1], e0[0]);
      end
      total++;
      if ({rq[1].c, rq[1].err} !== e1 || rq[1].tag !== 5'd10) begin
        bad++; $display("FAIL sign_abs: c=%h err=%b tag=%0d want %h/%b/10",
                        rq[1].c, rq[1].err, rq[1].tag, e1[32:1], e1[0]);
      end
      total++;
      if ({rq[2].c, rq[2].err, rq[2].tag} !== {32'h7FC0_0000, 1'b1, 5'd11}) begin
        bad++; $display("FAIL sign_illegal: c=%h err=%b tag=%0d want 7fc00000/1/11",
                        rq[2].c, rq[2].err, rq[2].tag);
      end
    end
  endtask

  task automatic test_int_stall();
    int n;
    @(negedge clk);
    bus.result_ready = 1'b0;
    rq.delete();
    send(3'd0, 32'd7, 32'd8, 5'd10);
    idle();
    n = 0;
    #1;
    while (!bus.result_valid && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if ({bus.result_valid, bus.result_tag} !== {1'b1, 5'd10}) begin
      bad++; $display("FAIL stall_prep: v=%b tag=%0d want 1/10",
                      bus.result_valid, bus.result_tag);
    end
    send(3'd7, 32'd0, 32'd0, 5'd11);
    @(negedge clk);
    bus.tag = 5'd12;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL stall_hold_%0d: in_ready=%b want 0", k, bus.in_ready);
      end
      @(negedge clk);
    end
    bus.result_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release: in_ready=%b want 1", bus.in_ready);
    end
    idle();
    wait_results(3, "stall");
    if (rq.size() >= 3) begin
      total++;
      if ({rq[0].tag, rq[0].c, rq[0].err} !== {5'd10, 32'd15, 1'b0}) begin
        bad++; $display("FAIL stall_r0: tag=%0d c=%h want 10/f", rq[0].tag, rq[0].c);
      end
      total++;
      if ({rq[1].tag, rq[1].c, rq[1].err} !== {5'd11, 32'h7FC0_0000, 1'b1} ||
          {rq[2].tag, rq[2].c, rq[2].err} !== {5'd12, 32'h7FC0_0000, 1'b1}) begin
        bad++; $display("FAIL stall_r12: tags=%0d,%0d errs=%b%b want 11,12 11",
                        rq[1].tag, rq[2].tag, rq[1].err, rq[2].err);
      end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    bus.result_ready = 1'b0;
    rq.delete();
    send(3'd0, 32'd1, 32'd1, 5'd20);
    send(3'd0, 32'd1, 32'd1, 5'd21);
    send(3'd0, 32'd1, 32'd1, 5'd22);
    idle();
    #1;
    total++;
    if (inflight !== 4'd3) begin
      bad++; $display("FAIL mid_inflight3: got %0d want 3", inflight);
    end
    @(negedge clk);
    init = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_init_ready: got %b want 0", bus.in_ready);
    end
    @(negedge clk);
    init = 1'b0;
    #1;
    total++;
    if ({inflight, bus.result_valid, unit_aresetn} !== 6'd0) begin
      bad++; $display("FAIL mid_cleared: infl=%0d v=%b aresetn=%b want 0/0/0",
                      inflight, bus.result_valid, unit_aresetn);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      #1;
      total++;
      if ({bus.in_ready, unit_aresetn} !== {2{k == 3}}) begin
        bad++; $display("FAIL mid_release k=%0d: rdy=%b aresetn=%b want %b",
                        k, bus.in_ready, unit_aresetn, k == 3);
      end
    end
    bus.result_ready = 1'b1;
    repeat (40) @(negedge clk);
    #3;
    total++;
    if (rq.size() != 0) begin
      bad++; $display("FAIL mid_stale: got %0d results want 0", rq.size());
    end
    send(3'd2, 32'd4, 32'd5, 5'd7);
    idle();
    wait_results(1, "mid_after");
    if (rq.size() >= 1) begin
      total++;
      if ({rq[0].tag, rq[0].c, rq[0].err} !== {5'd7, 32'd11, 1'b0}) begin
        bad++; $display("FAIL mid_after: tag=%0d c=%0d want 7/11", rq[0].tag, rq[0].c);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.operator = 3'd0;
    bus.a = '0;
    bus.b = '0;
    bus.tag = '0;
    bus.result_ready = 1'b0;
    test_reset();
    test_order();
    test_fill_drain();
    test_signop();
    test_int_stall();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
